// File: rtl/rv32i_alu_issue.sv
// rv32i_alu_issue -- decode-and-issue sequencer in front of an RV32I ALU.
//
// Takes one instruction plus its register operands over a valid/ready
// handshake and decodes OP, OP-IMM, BRANCH, LUI and AUIPC. It drives the
// external ALU for one cycle, then registers the result and the branch
// decision. The result is held for downstream on a second valid/ready
// handshake.
//
// Optional build macro: RV_SHAMT_CHECK_EN. When it is defined, non-zero
// funct7 bits on SLLI/SRLI/SRAI (other than the SRAI select bit) flag
// res_illegal.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   instr_valid/instr_ready  instruction handshake
//   instr, pc                instruction word and its PC
//   rs1_data, rs2_data       register-file operands
//   alu_a, alu_b, alu_ctrl   ALU operands and control code, valid in EXEC
//   alu_out                  combinational ALU result
//   res_valid/res_ready      result handshake
//   res_data, res_rd, res_we result value, destination register, write enable
//   br_taken, br_target      branch decision and target (pc + B-immediate)
//   res_illegal              unsupported or illegal encoding
module rv32i_alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_out,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic [4:0]      res_rd,
  output logic            res_we,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            res_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

  state_t state_q, state_d;

  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q;

  logic [XLEN-1:0] res_data_q, br_target_q;
  logic [4:0]      res_rd_q;
  logic            res_we_q, br_taken_q, res_illegal_q;

  // Decode of the latched instruction
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_u, imm_b;
  logic [XLEN-1:0] dec_a, dec_b;
  logic [3:0]      dec_ctrl;
  logic            dec_we, dec_branch, dec_illegal;
  logic            cond_true;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign rd     = instr_q[11:7];
  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_u  = {instr_q[31:12], 12'b0};
  assign imm_b  = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};

  always_comb begin
    dec_a       = '0;
    dec_b       = '0;
    dec_ctrl    = 4'b0000;
    dec_we      = 1'b0;
    dec_branch  = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a    = rs1_q;
        dec_b    = rs2_q;
        dec_ctrl = {instr_q[30], funct3};
        dec_we   = 1'b1;
        // Only ADD/SUB and SRL/SRA have an alternate form
        dec_illegal = instr_q[30] && (funct3 != 3'b000) && (funct3 != 3'b101);
      end
      OPC_OP_IMM: begin
        dec_a    = rs1_q;
        dec_b    = imm_i;
        dec_ctrl = {(funct3 == 3'b101) & instr_q[30], funct3};
        dec_we   = 1'b1;
`ifdef RV_SHAMT_CHECK_EN
        if (funct3 == 3'b001)
          dec_illegal = instr_q[31] | instr_q[30] | (|instr_q[29:26]) | instr_q[25];
        else if (funct3 == 3'b101)
          dec_illegal = instr_q[31] | (|instr_q[29:26]) | instr_q[25];
`else
        dec_illegal = 1'b0;
`endif
      end
      OPC_LUI: begin
        dec_b  = imm_u;
        dec_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a  = pc_q;
        dec_b  = imm_u;
        dec_we = 1'b1;
      end
      OPC_BRANCH: begin
        dec_a      = rs1_q;
        dec_b      = rs2_q;
        dec_branch = 1'b1;
        case (funct3)
          3'b000, 3'b001: dec_ctrl = 4'b1000;  // subtract, zero test here
          3'b100, 3'b101: dec_ctrl = 4'b0010;  // SLT
          3'b110, 3'b111: dec_ctrl = 4'b0011;  // SLTU
          default:        dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Branch condition; odd funct3 values are the inverted forms
  always_comb begin
    cond_true = 1'b0;
    case (funct3)
      3'b000:         cond_true = (alu_out == '0);
      3'b001:         cond_true = (alu_out != '0);
      3'b100, 3'b110: cond_true = alu_out[0];
      3'b101, 3'b111: cond_true = ~alu_out[0];
      default:        cond_true = 1'b0;
    endcase
  end

  // FSM next state and handshake / ALU outputs
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    res_valid   = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_ctrl    = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        instr_ready = ~reset;
        if (instr_valid) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!reset) begin
          alu_a    = dec_a;
          alu_b    = dec_b;
          alu_ctrl = dec_ctrl;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        res_valid = ~reset;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      pc_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      res_data_q    <= '0;
      res_rd_q      <= '0;
      res_we_q      <= 1'b0;
      br_taken_q    <= 1'b0;
      br_target_q   <= '0;
      res_illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && instr_valid) begin
        instr_q <= instr;
        pc_q    <= pc;
        rs1_q   <= rs1_data;
        rs2_q   <= rs2_data;
      end
      if (state_q == ST_EXEC) begin
        res_data_q    <= dec_illegal ? '0 : alu_out;
        res_rd_q      <= rd;
        res_we_q      <= dec_we & ~dec_illegal & (rd != 5'd0);
        br_taken_q    <= dec_branch & ~dec_illegal & cond_true;
        // Target comes from a local adder so the ALU stays free for the compare
        br_target_q   <= (dec_branch & ~dec_illegal) ? (pc_q + imm_b) : '0;
        res_illegal_q <= dec_illegal;
      end
    end
  end

  assign res_data    = res_data_q;
  assign res_rd      = res_rd_q;
  assign res_we      = res_we_q;
  assign br_taken    = br_taken_q;
  assign br_target   = br_target_q;
  assign res_illegal = res_illegal_q;

endmodule

// File: tb/tb_rv32i_alu_issue.sv
module tb_rv32i_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_ctrl;
  logic        res_valid, res_ready;
  logic [31:0] res_data, br_target;
  logic [4:0]  res_rd;
  logic        res_we, br_taken, res_illegal;

  always #5 clk = ~clk;

  rv32i_alu_issue #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd), .res_we(res_we),
    .br_taken(br_taken), .br_target(br_target), .res_illegal(res_illegal)
  );

  // Behavioural RV32I ALU on the far side of the block
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_out = alu_a + alu_b;
      4'b1000: alu_out = alu_a - alu_b;
      4'b0001: alu_out = alu_a << alu_b[4:0];
      4'b0010: alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'b0011: alu_out = {31'b0, alu_a < alu_b};
      4'b0100: alu_out = alu_a ^ alu_b;
      4'b0101: alu_out = alu_a >> alu_b[4:0];
      4'b1101: alu_out = $signed(alu_a) >>> alu_b[4:0];
      4'b0110: alu_out = alu_a | alu_b;
      4'b0111: alu_out = alu_a & alu_b;
      default: alu_out = 32'h0;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Observations from the last transaction
  logic [3:0]  o_ctrl;
  logic [31:0] o_a, o_b, o_data, o_target;
  logic [4:0]  o_rd;
  logic        o_we, o_taken, o_ill;
  logic        o_exec_valid, o_exec_ready, o_timeout, o_stable, o_ready_stall, o_idle_after;
  int          o_lat;
  longint      o_acc_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        taken;
    logic [31:0] target;
    logic        ill;
    logic [3:0]  ctrl;
  } exp_t;

  function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Reference model: architectural result of one instruction
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [2:0]  f3;
    logic [31:0] immi, immu, immb;
    f3   = i[14:12];
    immi = 32'($signed(i) >>> 20);
    immu = i & 32'hFFFFF000;
    immb = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    e    = '0;
    e.rd = i[11:7];
    case (i[6:0])
      7'h33: begin
        e.ill  = i[30] && !(f3 == 3'd0 || f3 == 3'd5);
        e.ctrl = {i[30], f3};
        e.data = arith(f3, i[30], r1, r2);
        e.we   = 1'b1;
      end
      7'h13: begin
        e.ctrl = {(f3 == 3'd5) && i[30], f3};
        e.data = arith(f3, (f3 == 3'd5) && i[30], r1, immi);
        e.we   = 1'b1;
      end
      7'h37: begin e.data = immu;     e.we = 1'b1; end
      7'h17: begin e.data = p + immu; e.we = 1'b1; end
      7'h63: begin
        e.target = p + immb;
        case (f3)
          3'd0: begin e.ctrl = 4'b1000; e.data = r1 - r2; e.taken = (r1 == r2); end
          3'd1: begin e.ctrl = 4'b1000; e.data = r1 - r2; e.taken = (r1 != r2); end
          3'd4: begin e.ctrl = 4'b0010; e.taken = $signed(r1) < $signed(r2);  e.data = {31'b0, e.taken}; end
          3'd5: begin e.ctrl = 4'b0010; e.taken = $signed(r1) >= $signed(r2); e.data = {31'b0, !e.taken}; end
          3'd6: begin e.ctrl = 4'b0011; e.taken = r1 < r2;  e.data = {31'b0, e.taken}; end
          3'd7: begin e.ctrl = 4'b0011; e.taken = r1 >= r2; e.data = {31'b0, !e.taken}; end
          default: e.ill = 1'b1;
        endcase
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.data = '0; e.we = 1'b0; e.taken = 1'b0; e.target = '0;
    end
    if (e.rd == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  // Drive one instruction, hold the result for 'stall' cycles, then accept it.
  // Starts and ends on a falling edge.
  task automatic send(input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] r1, input logic [31:0] r2, input int stall);
    int k;
    o_timeout = 1'b0; o_stable = 1'b1; o_ready_stall = 1'b0;
    k = 0;
    while (!instr_ready && k < 20) begin @(negedge clk); k++; end
    if (!instr_ready) o_timeout = 1'b1;
    instr = i; pc = p; rs1_data = r1; rs2_data = r2; instr_valid = 1'b1;
    @(posedge clk);
    o_acc_t = longint'($time);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = $urandom; pc = $urandom; rs1_data = $urandom; rs2_data = $urandom;
    o_ctrl = alu_ctrl; o_a = alu_a; o_b = alu_b;
    o_exec_valid = res_valid; o_exec_ready = instr_ready;
    o_lat = 1;
    while (!res_valid && o_lat < 10) begin @(negedge clk); o_lat++; end
    if (!res_valid) o_timeout = 1'b1;
    o_data = res_data; o_rd = res_rd; o_we = res_we; o_taken = br_taken;
    o_target = br_target; o_ill = res_illegal;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (!res_valid || res_data !== o_data || res_rd !== o_rd || res_we !== o_we ||
          br_taken !== o_taken || br_target !== o_target || res_illegal !== o_ill)
        o_stable = 1'b0;
      if (instr_ready) o_ready_stall = 1'b1;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    o_idle_after = instr_ready;
    $display("txn instr=%08h pc=%08h rs1=%08h rs2=%08h ctrl=%b data=%08h rd=%0d we=%b taken=%b tgt=%08h ill=%b lat=%0d",
             i, p, r1, r2, o_ctrl, o_data, o_rd, o_we, o_taken, o_target, o_ill, o_lat);
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b0; res_ready = 1'b0;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_instr_ready: got %b expected 0", instr_ready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    n_checks++; if (alu_ctrl !== 4'b0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin n_fail++; $display("FAIL reset_alu: got ctrl=%b a=%h b=%h expected zeros", alu_ctrl, alu_a, alu_b); end
    n_checks++; if (res_data !== 32'h0 || res_we !== 1'b0 || br_taken !== 1'b0 || res_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_res: got data=%h we=%b taken=%b ill=%b expected zeros", res_data, res_we, br_taken, res_illegal); end
    reset = 1'b0;
    #1;
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", instr_ready); end
  endtask

  task automatic test_add();
    send(32'h002081B3, 32'h0, 32'd5, 32'd7, 0);
    n_checks++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL add_timeout: got %b expected 0", o_timeout); end
    n_checks++; if (o_ctrl !== 4'b0000) begin n_fail++; $display("FAIL add_ctrl: got %b expected 0000", o_ctrl); end
    n_checks++; if (o_a !== 32'd5 || o_b !== 32'd7) begin n_fail++; $display("FAIL add_operands: got a=%h b=%h expected 5 7", o_a, o_b); end
    n_checks++; if (o_exec_valid !== 1'b0 || o_exec_ready !== 1'b0) begin n_fail++; $display("FAIL add_exec_flags: got valid=%b ready=%b expected 0 0", o_exec_valid, o_exec_ready); end
    n_checks++; if (o_lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d expected 2", o_lat); end
    n_checks++; if (o_data !== 32'd12) begin n_fail++; $display("FAIL add_data: got %h expected 0000000c", o_data); end
    n_checks++; if (o_rd !== 5'd3 || o_we !== 1'b1) begin n_fail++; $display("FAIL add_wb: got rd=%0d we=%b expected 3 1", o_rd, o_we); end
    n_checks++; if (o_idle_after !== 1'b1) begin n_fail++; $display("FAIL add_idle_after: got %b expected 1", o_idle_after); end
  endtask

  task automatic test_sub();
    send(32'h402081B3, 32'h0, 32'd5, 32'd7, 0);
    n_checks++; if (o_ctrl !== 4'b1000) begin n_fail++; $display("FAIL sub_ctrl: got %b expected 1000", o_ctrl); end
    n_checks++; if (o_data !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL sub_data: got %h expected fffffffe", o_data); end
  endtask

  task automatic test_srai();
    send(32'h4040D293, 32'h0, 32'h80000000, 32'h0, 0);
    n_checks++; if (o_ctrl !== 4'b1101) begin n_fail++; $display("FAIL srai_ctrl: got %b expected 1101", o_ctrl); end
    n_checks++; if (o_b !== 32'h00000404) begin n_fail++; $display("FAIL srai_imm: got %h expected 00000404", o_b); end
    n_checks++; if (o_data !== 32'hF8000000) begin n_fail++; $display("FAIL srai_data: got %h expected f8000000", o_data); end
    n_checks++; if (o_rd !== 5'd5 || o_ill !== 1'b0) begin n_fail++; $display("FAIL srai_rd: got rd=%0d ill=%b expected 5 0", o_rd, o_ill); end
  endtask

  task automatic test_beq();
    send(32'h00208463, 32'h100, 32'd9, 32'd9, 0);
    n_checks++; if (o_ctrl !== 4'b1000) begin n_fail++; $display("FAIL beq_ctrl: got %b expected 1000", o_ctrl); end
    n_checks++; if (o_taken !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got %b expected 1", o_taken); end
    n_checks++; if (o_target !== 32'h108) begin n_fail++; $display("FAIL beq_target: got %h expected 00000108", o_target); end
    n_checks++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL beq_we: got %b expected 0", o_we); end
    send(32'h00208463, 32'h100, 32'd9, 32'd8, 0);
    n_checks++; if (o_taken !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken: got %b expected 0", o_taken); end
    n_checks++; if (o_target !== 32'h108) begin n_fail++; $display("FAIL beq_nt_target: got %h expected 00000108", o_target); end
  endtask

  task automatic test_backpressure();
    send(32'h123453B7, 32'h0, 32'h0, 32'h0, 3);
    n_checks++; if (o_data !== 32'h12345000) begin n_fail++; $display("FAIL lui_data: got %h expected 12345000", o_data); end
    n_checks++; if (o_rd !== 5'd7 || o_we !== 1'b1) begin n_fail++; $display("FAIL lui_wb: got rd=%0d we=%b expected 7 1", o_rd, o_we); end
    n_checks++; if (o_stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b expected 1", o_stable); end
    n_checks++; if (o_ready_stall !== 1'b0) begin n_fail++; $display("FAIL bp_instr_ready: got %b expected 0", o_ready_stall); end
    n_checks++; if (o_idle_after !== 1'b1) begin n_fail++; $display("FAIL bp_idle_after: got %b expected 1", o_idle_after); end
  endtask

  task automatic test_illegal();
    send(32'h0000007F, 32'h40, 32'd3, 32'd4, 0);
    n_checks++; if (o_ill !== 1'b1) begin n_fail++; $display("FAIL ill_flag: got %b expected 1", o_ill); end
    n_checks++; if (o_we !== 1'b0 || o_taken !== 1'b0 || o_data !== 32'h0) begin n_fail++; $display("FAIL ill_result: got we=%b taken=%b data=%h expected 0 0 0", o_we, o_taken, o_data); end
    n_checks++; if (o_lat !== 2) begin n_fail++; $display("FAIL ill_latency: got %0d expected 2", o_lat); end
  endtask

  task automatic test_reset_mid();
    logic seen_valid;
    instr = 32'h002081B3; pc = 32'h0; rs1_data = 32'd1; rs2_data = 32'd2; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++; if (instr_ready !== 1'b0 || alu_ctrl !== 4'b0 || alu_a !== 32'h0) begin n_fail++; $display("FAIL midrst_outputs: got ready=%b ctrl=%b a=%h expected 0 0 0", instr_ready, alu_ctrl, alu_a); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", instr_ready); end
    seen_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) seen_valid = 1'b1;
    end
    n_checks++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_result: got %b expected 0", seen_valid); end
    n_checks++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL midrst_res_data: got %h expected 0", res_data); end
  endtask

  task automatic test_back_to_back();
    longint t0, t1;
    send(32'h002081B3, 32'h0, 32'd1, 32'd1, 0);
    t0 = o_acc_t;
    send(32'h402081B3, 32'h0, 32'd1, 32'd1, 0);
    t1 = o_acc_t;
    n_checks++; if (t1 - t0 != 64'd30) begin n_fail++; $display("FAIL b2b_interval: got %0d expected 30", t1 - t0); end
    t0 = t1;
    send(32'h123453B7, 32'h0, 32'd1, 32'd1, 0);
    n_checks++; if (o_acc_t - t0 != 64'd30) begin n_fail++; $display("FAIL b2b_interval2: got %0d expected 30", o_acc_t - t0); end
  endtask

  task automatic test_random();
    logic [31:0] i, p, r1, r2;
    logic [2:0]  f3;
    exp_t        e;
    int          kind;
    for (int t = 0; t < 60; t++) begin
      i = $urandom; p = $urandom; r1 = $urandom; r2 = $urandom;
      f3 = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin i[6:0] = 7'h33; i[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
        1: begin
          i[6:0] = 7'h13;
          if (f3 == 3'd1) i[31:25] = 7'h00;
          if (f3 == 3'd5) i[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        end
        2: i[6:0] = 7'h37;
        3: i[6:0] = 7'h17;
        4: begin
          i[6:0] = 7'h63;
          if (f3 == 3'd2 || f3 == 3'd3) f3 = {1'b1, f3[1:0]};
          if ($urandom_range(0, 2) == 0) r2 = r1;
        end
        default: i[6:0] = ($urandom_range(0, 1) != 0) ? 7'h7F : 7'h03;
      endcase
      if (kind <= 1 || kind == 4) i[14:12] = f3;
      e = model(i, p, r1, r2);
      send(i, p, r1, r2, $urandom_range(0, 3));
      n_checks++; if (o_timeout !== 1'b0 || o_lat !== 2) begin n_fail++; $display("FAIL rnd%0d_latency: got lat=%0d timeout=%b expected 2 0", t, o_lat, o_timeout); end
      n_checks++; if (o_ctrl !== e.ctrl) begin n_fail++; $display("FAIL rnd%0d_ctrl: instr=%h got %b expected %b", t, i, o_ctrl, e.ctrl); end
      n_checks++; if (o_data !== e.data) begin n_fail++; $display("FAIL rnd%0d_data: instr=%h got %h expected %h", t, i, o_data, e.data); end
      n_checks++; if (o_rd !== e.rd || o_we !== e.we) begin n_fail++; $display("FAIL rnd%0d_wb: instr=%h got rd=%0d we=%b expected %0d %b", t, i, o_rd, o_we, e.rd, e.we); end
      n_checks++; if (o_taken !== e.taken || o_target !== e.target) begin n_fail++; $display("FAIL rnd%0d_branch: instr=%h got taken=%b tgt=%h expected %b %h", t, i, o_taken, o_target, e.taken, e.target); end
      n_checks++; if (o_ill !== e.ill) begin n_fail++; $display("FAIL rnd%0d_illegal: instr=%h got %b expected %b", t, i, o_ill, e.ill); end
      n_checks++; if (o_stable !== 1'b1 || o_idle_after !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_handshake: got stable=%b idle=%b expected 1 1", t, o_stable, o_idle_after); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_srai();
    test_beq();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
